// File: rtl/apb_bridge_pkg.sv
// ============================================================================
// Module      : apb_bridge_pkg
// Description : Shared types and constants for the AHB-to-APB bridge controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package apb_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WWAIT   = 3'd1,
        READ    = 3'd2,
        RENABLE = 3'd3,
        WRITE   = 3'd4,
        WENABLE = 3'd5
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [31:0] P0_BASE  = 32'h8000_0000;
    localparam logic [31:0] P0_LIMIT = 32'h83FF_FFFF;
    localparam logic [31:0] P1_BASE  = 32'h8400_0000;
    localparam logic [31:0] P1_LIMIT = 32'h87FF_FFFF;
    localparam logic [31:0] P2_BASE  = 32'h8800_0000;
    localparam logic [31:0] P2_LIMIT = 32'h8BFF_FFFF;

    localparam logic [2:0] SEL_P0 = 3'b001;
    localparam logic [2:0] SEL_P1 = 3'b010;
    localparam logic [2:0] SEL_P2 = 3'b100;

endpackage

`default_nettype wire

// File: rtl/apb_bridge_if.sv
// ============================================================================
// Module      : apb_bridge_if
// Description : AHB slave-side and APB master-side signals of the bridge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface apb_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int NSEL   = 3
);
    logic [1:0]        Htrans;
    logic              Hwrite;
    logic [ADDR_W-1:0] Haddr;
    logic [DATA_W-1:0] Hwdata;
    logic              Hreadyin;
    logic [DATA_W-1:0] prdata;
    logic              pwrite;
    logic              penable;
    logic [NSEL-1:0]   pselx;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic              Hreadyout;
    logic [DATA_W-1:0] Hrdata;
    logic [1:0]        Hresp;

    // Bridge side
    modport slave (
        input  Htrans, Hwrite, Haddr, Hwdata, Hreadyin, prdata,
        output pwrite, penable, pselx, paddr, pwdata, Hreadyout, Hrdata, Hresp
    );

    // AHB master / APB stage side
    modport master (
        output Htrans, Hwrite, Haddr, Hwdata, Hreadyin, prdata,
        input  pwrite, penable, pselx, paddr, pwdata, Hreadyout, Hrdata, Hresp
    );
endinterface

`default_nettype wire

// File: rtl/apb_addr_decode.sv
// ============================================================================
// Module      : apb_addr_decode
// Description : Combinational AHB transfer qualification and APB region decode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_addr_decode
    import apb_bridge_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  wire  [1:0]        Htrans,
    input  wire  [ADDR_W-1:0] Haddr,
    input  wire               Hreadyin,
    output logic              valid,
    output logic [2:0]        tempselx
);

    // Only Htrans[1] separates NONSEQ/SEQ from IDLE/BUSY.
    wire w_unused_htrans = Htrans[0];

    always_comb begin
        tempselx = 3'b000;
        if (Haddr >= P0_BASE && Haddr <= P0_LIMIT)
            tempselx = SEL_P0;
        else if (Haddr >= P1_BASE && Haddr <= P1_LIMIT)
            tempselx = SEL_P1;
        else if (Haddr >= P2_BASE && Haddr <= P2_LIMIT)
            tempselx = SEL_P2;
        valid = Hreadyin & Htrans[1] & (tempselx != 3'b000);
    end

endmodule

`default_nettype wire

// File: rtl/apb_bridge_controller.sv
// ============================================================================
// Module      : apb_bridge_controller
// Description : Sequences decoded AHB transfers through APB SETUP/ENABLE phases.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_bridge_controller
    import apb_bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int NSEL   = 3
) (
    input wire          Hclk,
    input wire          Hreset,
    apb_bridge_if.slave bus
);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr_q;
    logic [NSEL-1:0]   r_sel_q;
    logic              r_dir_q;
    logic [DATA_W-1:0] r_wdata_q;
    logic              w_valid;
    logic [2:0]        w_tempselx;
    logic              w_hready;
    logic              w_accept;

    apb_addr_decode #(
        .ADDR_W (ADDR_W)
    ) u_decode (
        .Htrans   (bus.Htrans),
        .Haddr    (bus.Haddr),
        .Hreadyin (bus.Hreadyin),
        .valid    (w_valid),
        .tempselx (w_tempselx)
    );

    assign w_hready = (r_state == IDLE) || (r_state == RENABLE) || (r_state == WENABLE);
    assign w_accept = w_valid & w_hready;

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            r_state   <= IDLE;
            r_addr_q  <= '0;
            r_sel_q   <= '0;
            r_dir_q   <= 1'b0;
            r_wdata_q <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_addr_q <= bus.Haddr;
                r_sel_q  <= w_tempselx;
                r_dir_q  <= bus.Hwrite;
            end
            // Write data arrives one cycle after the address phase.
            if (r_state == WWAIT)
                r_wdata_q <= bus.Hwdata;
        end
    end

    always_comb begin
        w_next = IDLE;
        case (r_state)
            IDLE, RENABLE, WENABLE: begin
                if (w_valid)
                    w_next = bus.Hwrite ? WWAIT : READ;
                else
                    w_next = IDLE;
            end
            READ:    w_next = RENABLE;
            WWAIT:   w_next = WRITE;
            WRITE:   w_next = WENABLE;
            default: w_next = IDLE;
        endcase
    end

    assign bus.pselx     = ((r_state == READ) || (r_state == RENABLE) ||
                            (r_state == WRITE) || (r_state == WENABLE)) ? r_sel_q : '0;
    assign bus.penable   = (r_state == RENABLE) || (r_state == WENABLE);
    assign bus.pwrite    = r_dir_q & ((r_state == WRITE) || (r_state == WENABLE));
    assign bus.paddr     = r_addr_q;
    assign bus.pwdata    = r_wdata_q;
    assign bus.Hreadyout = w_hready;
    assign bus.Hrdata    = (r_state == RENABLE) ? bus.prdata : '0;
    assign bus.Hresp     = 2'b00;

endmodule

`default_nettype wire

// File: doc/apb_bridge_controller.md
Name: apb_bridge_controller

Overview:
AHB-side bridge controller that sits directly upstream of the APB interface stage. It decodes AHB transfers into the APB peripheral map and sequences each one through APB SETUP and ENABLE phases. It drives pwrite/penable/pselx/paddr/pwdata into the APB interface stage and returns prdata to the AHB master. It inserts wait states on Hreadyout while an APB access is in flight.

Parameters:
ADDR_W, 32, AHB/APB address width
DATA_W, 32, AHB/APB data width
NSEL, 3, number of one-hot APB slave selects

Ports:
Hclk  in  1  system clock; all logic on rising edge
Hreset  in  1  synchronous, active-high reset
Htrans  in  2  AHB transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
Hwrite  in  1  AHB write=1, read=0 (address phase)
Haddr  in  ADDR_W  AHB address (address phase)
Hwdata  in  DATA_W  AHB write data (data phase)
Hreadyin  in  1  global AHB HREADY
prdata  in  DATA_W  read data returned by the APB interface stage
pwrite  out  1  APB direction
penable  out  1  APB enable phase
pselx  out  NSEL  one-hot APB slave select
paddr  out  ADDR_W  APB address
pwdata  out  DATA_W  APB write data
Hreadyout  out  1  AHB ready; 0 inserts a wait state
Hrdata  out  DATA_W  read data to the AHB master
Hresp  out  2  AHB response; constant 2'b00 (OKAY)

Behaviour:
- Decode (combinational): valid = Hreadyin & Htrans[1] & (Haddr in 0x8000_0000..0x8BFF_FFFF).
  - 0x8000_0000–0x83FF_FFFF -> sel 001; 0x8400_0000–0x87FF_FFFF -> 010; 0x8800_0000–0x8BFF_FFFF -> 100.
  - Out-of-range addresses and IDLE/BUSY transfers produce no APB activity and receive Hresp OKAY.
- Address capture: when valid is sampled in a state where Hreadyout=1, latch Haddr to addr_q, sel to sel_q and Hwrite to dir_q.
- Outputs are Moore-decoded from the state register and the q registers.
- States and outputs:
  - IDLE: Hreadyout=1; pselx=0; penable=0.
    - valid & !Hwrite -> READ; valid & Hwrite -> WWAIT; else stay in IDLE.
  - READ (APB setup): pselx=sel_q; paddr=addr_q; pwrite=0; penable=0; Hreadyout=0. Always -> RENABLE.
  - RENABLE: pselx=sel_q; penable=1; pwrite=0; Hreadyout=1; Hrdata=prdata (combinational pass-through).
    - Then: valid & !Hwrite -> READ; valid & Hwrite -> WWAIT; else IDLE.
  - WWAIT (AHB write data phase): Hreadyout=0; pselx=0; latch Hwdata into wdata_q. Always -> WRITE.
  - WRITE (APB setup): pselx=sel_q; paddr=addr_q; pwdata=wdata_q; pwrite=1; penable=0; Hreadyout=0. Always -> WENABLE.
  - WENABLE: same as WRITE but penable=1; Hreadyout=1. Next-state rule is the same as RENABLE.
- Latency, counted in Hclk cycles from the first data-phase cycle: read = 2 (READ, RENABLE); write = 3 (WWAIT, WRITE, WENABLE).
- Back-to-back transfers: a new transfer accepted in RENABLE/WENABLE starts its SETUP (or WWAIT) on the very next cycle; there is no return to IDLE.
- Hrdata is 0 in every state other than RENABLE.
- pwdata holds wdata_q in all states (stable across reads).
- paddr holds addr_q in all states.
- Signals presented while Hreadyout=0 are ignored; the AHB master holds them until Hreadyout=1.
- Reset:
  - Hreset sampled high -> next state IDLE, and addr_q, sel_q, dir_q, wdata_q cleared to 0.
  - After that edge all outputs are 0, except Hreadyout=1 and Hresp=00.
  - Reset asserted mid-transfer aborts it; penable and pselx drop on the first edge where Hreset is high.

Decomposition:
- Package apb_bridge_pkg holds:
  - state enum: IDLE, WWAIT, READ, RENABLE, WRITE, WENABLE;
  - HTRANS codes;
  - region base/limit constants;
  - select codes SEL_P0=001, SEL_P1=010, SEL_P2=100.
- One sub-module, apb_addr_decode (purely combinational): inputs Htrans, Haddr, Hreadyin; outputs valid and tempselx.
- The FSM and holding registers live in the top module.

Test Plan:
- Single read: after reset, NONSEQ read at 0x8000_0010 with prdata=0x0000_0019.
  - Expect READ then RENABLE: pselx=001, paddr=0x8000_0010, penable low then high.
  - Expect Hreadyout 0 then 1, and Hrdata=0x19 in RENABLE.
- Single write: NONSEQ write at 0x8400_0020 with Hwdata=0xDEAD_BEEF.
  - Expect WWAIT, WRITE, WENABLE: pselx=010, pwrite=1, pwdata=0xDEAD_BEEF.
  - Expect penable high only in WENABLE, and Hreadyout 0,0,1.
- Back-to-back: read at 0x8800_0000 held valid into RENABLE, then write at 0x8000_0004 (data 0x1234_5678).
  - Expect RENABLE -> WWAIT with no IDLE cycle, pselx 100 then 001.
- Ignored transfers: Htrans=00 at 0x8000_0000, then NONSEQ at 0x9000_0000.
  - Expect the FSM to stay in IDLE with pselx=0, Hreadyout=1 and Hresp=00 throughout.
- Reset mid-transfer: assert Hreset during WRITE.
  - Expect IDLE, penable=0, pselx=0, pwdata=0 and Hreadyout=1 after the next edge.
  - Expect a subsequent read to complete normally.
